imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/byte_pair_assembler.sv | 41 ++++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 32;
  localparam int IMEM_DATA_W = 16;
  localparam int BYTE_W      = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE
  } state_t;

endpackage

// File: rtl/byte_pair_assembler.sv
// Packs accepted bytes little-endian into 16-bit words; word_valid pulses
// for one cycle after the high byte is accepted.
module byte_pair_assembler
  import imem_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   byte_valid,
  input  logic [BYTE_W-1:0]      byte_in,
  output logic                   word_valid,
  output logic [IMEM_DATA_W-1:0] word
);

  logic              phase_hi;
  logic [BYTE_W-1:0] low_byte;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      phase_hi   <= 1'b0;
      low_byte   <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid) begin
        if (!phase_hi) begin
          low_byte <= byte_in;
          phase_hi <= 1'b1;
        end else begin
          word       <= {byte_in, low_byte};
          word_valid <= 1'b1;
          phase_hi   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory while holding the
// CPU in reset. Define IMEM_LOADER_CHECKSUM_EN to verify a trailing XOR word.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [IMEM_ADDR_W-1:0] BASE_ADDR = 32'h0000_0020
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [BYTE_W-1:0]      in_byte,
  output logic                   in_ready,
  output logic                   write_enable,
  output logic [IMEM_ADDR_W-1:0] write_addr,
  output logic [IMEM_DATA_W-1:0] write_data,
  output logic                   cpu_hold,
  output logic                   load_done,
  output logic                   load_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = S_CHK;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  state_t                 state, state_next;
  logic                   start_load;
  logic                   word_valid;
  logic [IMEM_DATA_W-1:0] word;
  logic [IMEM_DATA_W-1:0] word_idx;
  logic [IMEM_DATA_W-1:0] word_count;
  logic [IMEM_ADDR_W-1:0] addr_hold;
  logic [IMEM_DATA_W-1:0] data_hold;

  byte_pair_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_load),
    .byte_valid (in_valid && in_ready),
    .byte_in    (in_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    cpu_hold     = 1'b1;
    start_load   = 1'b0;
    write_enable = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_LEN;
          start_load = 1'b1;
        end
      end
      S_LEN: begin
        in_ready = 1'b1;
        if (word_valid) state_next = (word == '0) ? END_STATE : S_DATA;
      end
      S_DATA: begin
        in_ready     = 1'b1;
        write_enable = word_valid;
        if (word_valid && (word_idx == word_count - 1'b1)) state_next = END_STATE;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (word_valid) state_next = S_DONE;
      end
`endif
      S_DONE: begin
        cpu_hold = 1'b0;
        if (start) begin
          state_next = S_LEN;
          start_load = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // A byte taken on the cycle the load finishes would belong to nothing.
    if (state_next == S_DONE && state != S_DONE) in_ready = 1'b0;
  end

  assign write_addr = write_enable ? BASE_ADDR + {16'b0, word_idx} : addr_hold;
  assign write_data = write_enable ? word : data_hold;
  assign load_done  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      word_idx   <= '0;
      word_count <= '0;
      addr_hold  <= BASE_ADDR;
      data_hold  <= '0;
    end else begin
      state <= state_next;
      if (start_load) word_idx <= '0;
      if (state == S_LEN && word_valid) word_count <= word;
      if (write_enable) begin
        word_idx  <= word_idx + 1'b1;
        addr_hold <= write_addr;
        data_hold <= write_data;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [IMEM_DATA_W-1:0] chk_acc;
  logic                   err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_acc <= '0;
      err_q   <= 1'b0;
    end else if (start_load) begin
      chk_acc <= '0;
      err_q   <= 1'b0;
    end else begin
      if (write_enable) chk_acc <= chk_acc ^ word;
      if (state == S_CHK && word_valid) err_q <= (word != chk_acc);
    end
  end

  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a queue-based model
// of the expected memory writes.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_ready;
  logic        write_enable;
  logic [31:0] write_addr;
  logic [15:0] write_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  logic [15:0] words_q[$];
  int          wr_count  = 0;
  int          exp_total = 0;
  logic [31:0] m_addr;
  logic [15:0] m_data;
  bit          armed = 1'b0;

  imem_loader #(.BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Model side: reset restores the hold values the outputs must show.
  always @(posedge clk) begin
    if (rst) begin
      m_addr = BASE;
      m_data = 16'h0000;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      if (write_enable) begin
        wr_count++;
        check("wr_unexpected", 32'(exp_addr_q.size() == 0), 0);
        if (exp_addr_q.size() > 0) begin
          m_addr = exp_addr_q.pop_front();
          m_data = exp_data_q.pop_front();
          check("wr_addr", write_addr, m_addr);
          check("wr_data", 32'(write_data), 32'(m_data));
        end
      end else begin
        check("hold_addr", write_addr, m_addr);
        check("hold_data", 32'(write_data), 32'(m_data));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      @(negedge clk);
    end
  endtask

  // Offer one byte until accepted; always returns on a falling edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int t = 0;
    idle($urandom_range(0, max_gap));
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int max_gap);
    send_byte(w[7:0], max_gap);
    send_byte(w[15:8], max_gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Load words_q; expected writes are BASE+k in order, checksum is XOR of all.
  task automatic do_load(input bit bad_chk, input bit poke_start, input int max_gap);
    logic [15:0] x = 16'h0000;
    int t = 0;
    for (int k = 0; k < words_q.size(); k++) begin
      exp_addr_q.push_back(BASE + 32'(k));
      exp_data_q.push_back(words_q[k]);
      x ^= words_q[k];
      exp_total++;
    end
    pulse_start();
    check("hold_after_start", 32'(cpu_hold), 1);
    send_word(16'(words_q.size()), max_gap);
    for (int k = 0; k < words_q.size(); k++) begin
      if (poke_start && k == 1) start = 1'b1;
      send_word(words_q[k], max_gap);
      start = 1'b0;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(bad_chk ? ~x : x, max_gap);
`endif
    while (!load_done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("load_done", 32'(load_done), 1);
    check("cpu_hold_done", 32'(cpu_hold), 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("load_err", 32'(load_err), 32'(bad_chk));
`else
    check("load_err", 32'(load_err), 0);
`endif
    check("wr_count", 32'(wr_count), 32'(exp_total));
  endtask

  initial begin
    // Reset wins over start and in_valid in the same cycles.
    start    = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    rst      = 1'b0;
    armed    = 1'b1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_we", 32'(write_enable), 0);
    check("rst_addr", write_addr, BASE);
    check("rst_data", 32'(write_data), 0);
    check("rst_cpu_hold", 32'(cpu_hold), 1);
    check("rst_load_done", 32'(load_done), 0);
    check("rst_load_err", 32'(load_err), 0);
    idle(3);
    check("idle_in_ready", 32'(in_ready), 0);

    // Three-word program.
    words_q = '{16'h0070, 16'h0071, 16'h0072};
    do_load(1'b0, 1'b0, 0);

    // Bytes offered in DONE are ignored.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      check("done_in_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("done_wr_count", 32'(wr_count), 32'(exp_total));

    // Empty program finishes two edges after the second length byte.
    pulse_start();
    send_byte(8'h00, 1);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(16'h0000, 0);
    idle(1);
    check("n0_done", 32'(load_done), 1);
    check("n0_err", 32'(load_err), 0);
`else
    check("n0_not_yet", 32'(load_done), 0);
    idle(1);
    check("n0_done", 32'(load_done), 1);
`endif
    check("n0_wr_count", 32'(wr_count), 32'(exp_total));

    // Low byte survives a five-cycle stall before the high byte.
    exp_addr_q.push_back(BASE);
    exp_data_q.push_back(16'h1234);
    exp_total++;
    pulse_start();
    send_word(16'h0001, 0);
    send_byte(8'h34, 0);
    idle(5);
    check("stall_no_write", 32'(wr_count), 32'(exp_total - 1));
    send_byte(8'h12, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(16'h1234, 0);
`endif
    idle(3);
    check("stall_done", 32'(load_done), 1);
    check("stall_wr_count", 32'(wr_count), 32'(exp_total));

    // Reset after the first of three data words aborts the load.
    exp_addr_q.push_back(BASE);
    exp_data_q.push_back(16'hBEEF);
    exp_total++;
    pulse_start();
    send_word(16'h0003, 0);
    send_word(16'hBEEF, 0);
    send_byte(8'h55, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cpu_hold", 32'(cpu_hold), 1);
    check("abort_in_ready", 32'(in_ready), 0);
    check("abort_done", 32'(load_done), 0);
    in_valid = 1'b1;
    idle(4);
    check("abort_wr_count", 32'(wr_count), 32'(exp_total));

    // Fresh load restarts at BASE; start held during DATA is ignored.
    words_q = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    do_load(1'b0, 1'b1, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    words_q = '{16'h00FF, 16'h0F0F};
    do_load(1'b0, 1'b0, 0);
    words_q = '{16'h00FF, 16'h0F0F};
    do_load(1'b1, 1'b0, 0);
`endif

    // Randomized loads with random gaps.
    for (int r = 0; r < 8; r++) begin
      words_q.delete();
      repeat ($urandom_range(1, 6)) words_q.push_back(16'($urandom));
      do_load($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 2);
      idle($urandom_range(0, 3));
    end

    check("exp_queue_drained", 32'(exp_addr_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
